// File: rtl/genius_display_pkg.sv
// Shared types and constants for the Genius display path:
// sequencer states, command opcodes, colors and sprite flag ordering.
package genius_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FLASH_ON,
        ST_FLASH_GAP,
        ST_LOSE,
        ST_WIN
    } state_e;

    localparam logic [1:0] OP_FLASH = 2'd0;
    localparam logic [1:0] OP_LOSE  = 2'd1;
    localparam logic [1:0] OP_WIN   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] COLOR_BLUE   = 2'd0;
    localparam logic [1:0] COLOR_GREEN  = 2'd1;
    localparam logic [1:0] COLOR_RED    = 2'd2;
    localparam logic [1:0] COLOR_YELLOW = 2'd3;

    // Bit order must match the VGA controller's sprite table.
    localparam int FLAG_BLUE   = 0;
    localparam int FLAG_GREEN  = 1;
    localparam int FLAG_RED    = 2;
    localparam int FLAG_YELLOW = 3;
    localparam int FLAG_LOSE   = 4;
    localparam int FLAG_WIN    = 5;
    localparam int FLAG_PWR    = 6;
    localparam int FLAG_W      = 7;

    function automatic logic [3:0] color_flag(input logic [1:0] color);
        return 4'b0001 << color;
    endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Falling-edge detector on active-low vertical sync.
// Produces a one-cycle frame tick at the start of each sync pulse.
module frame_tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic vs_n,
    output logic tick
);

    logic vs_q;
    logic vs_d;

    always_comb begin
        vs_d = vs_n;
    end

    // Resetting high suppresses a spurious tick right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vs_d;
        end
    end

    assign tick = vs_q & ~vs_n;

endmodule

// File: rtl/display_sequencer.sv
// Frame-synchronous sprite-flag sequencer: turns game display
// commands into sprite flags that change only at vertical sync.
module display_sequencer
    import genius_display_pkg::*;
#(
    parameter int FLASH_FRAMES = 30,
    parameter int GAP_FRAMES   = 10,
    parameter int BLINK_FRAMES = 15
) (
    input  logic              VGA_CLK,
    input  logic              RESET,
    input  logic              VGA_VS,
    input  logic              POWER_ON,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [1:0]        CMD_COLOR,
    output logic [FLAG_W-1:0] SPRITES_FLAGS,
    output logic              FLASH_DONE
);

    localparam logic [7:0] FLASH_RLD = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] GAP_RLD   = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] BLINK_RLD = 8'(BLINK_FRAMES - 1);

    logic tick;

    frame_tick_detect u_tick (
        .clk  (VGA_CLK),
        .rst  (RESET),
        .vs_n (VGA_VS),
        .tick (tick)
    );

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        color_q, color_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              done_q, done_d;
    logic              pwr_s1_q, pwr_s1_d;
    logic              pwr_s2_q, pwr_s2_d;
    logic              accept;

    always_comb begin
        CMD_READY = (state_q == ST_IDLE) ||
                    (state_q == ST_LOSE) ||
                    (state_q == ST_WIN);
    end

    assign accept = CMD_VALID & CMD_READY;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        color_d  = color_q;
        cnt_d    = cnt_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        pwr_s1_d = POWER_ON;
        pwr_s2_d = pwr_s1_q;

        if (tick) begin
            flags_d[FLAG_PWR] = pwr_s2_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = CMD_OP;
                    color_d = CMD_COLOR;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    flags_d[FLAG_WIN:FLAG_BLUE] = '0;
                    unique case (op_q)
                        OP_FLASH: begin
                            flags_d[FLAG_YELLOW:FLAG_BLUE] = color_flag(color_q);
                            cnt_d   = FLASH_RLD;
                            state_d = ST_FLASH_ON;
                        end
                        OP_LOSE: begin
                            flags_d[FLAG_LOSE] = 1'b1;
                            state_d = ST_LOSE;
                        end
                        OP_WIN: begin
                            flags_d[FLAG_WIN] = 1'b1;
                            cnt_d   = BLINK_RLD;
                            state_d = ST_WIN;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_FLASH_ON: begin
                if (tick) begin
                    if (cnt_q == 8'd0) begin
                        flags_d[FLAG_YELLOW:FLAG_BLUE] =
                            flags_q[FLAG_YELLOW:FLAG_BLUE] & ~color_flag(color_q);
                        cnt_d   = GAP_RLD;
                        state_d = ST_FLASH_GAP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_FLASH_GAP: begin
                if (tick) begin
                    if (cnt_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_LOSE: begin
                if (accept) begin
                    op_d    = CMD_OP;
                    color_d = CMD_COLOR;
                    state_d = ST_ARM;
                end
            end
            ST_WIN: begin
                if (tick) begin
                    if (cnt_q == 8'd0) begin
                        flags_d[FLAG_WIN] = ~flags_q[FLAG_WIN];
                        cnt_d = BLINK_RLD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                if (accept) begin
                    op_d    = CMD_OP;
                    color_d = CMD_COLOR;
                    state_d = ST_ARM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_FLASH;
            color_q  <= COLOR_BLUE;
            cnt_q    <= 8'd0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            pwr_s1_q <= 1'b0;
            pwr_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            color_q  <= color_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            pwr_s1_q <= pwr_s1_d;
            pwr_s2_q <= pwr_s2_d;
        end
    end

    assign SPRITES_FLAGS = flags_q;
    assign FLASH_DONE    = done_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed scoreboard bench for display_sequencer with short
// flash, gap and blink lengths.
module tb_display_sequencer;

    logic       VGA_CLK;
    logic       RESET;
    logic       VGA_VS;
    logic       POWER_ON;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic [1:0] CMD_COLOR;
    logic [6:0] SPRITES_FLAGS;
    logic       FLASH_DONE;

    int checks;
    int errors;

    typedef struct {
        logic [6:0] flags;
        int         done_n;
        int         rdy_n;
    } exp_t;

    exp_t sb[$];

    display_sequencer #(
        .FLASH_FRAMES (3),
        .GAP_FRAMES   (2),
        .BLINK_FRAMES (2)
    ) dut (
        .VGA_CLK       (VGA_CLK),
        .RESET         (RESET),
        .VGA_VS        (VGA_VS),
        .POWER_ON      (POWER_ON),
        .CMD_VALID     (CMD_VALID),
        .CMD_READY     (CMD_READY),
        .CMD_OP        (CMD_OP),
        .CMD_COLOR     (CMD_COLOR),
        .SPRITES_FLAGS (SPRITES_FLAGS),
        .FLASH_DONE    (FLASH_DONE)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic push(input logic [6:0] f, input int d, input int r);
        exp_t e;
        e.flags  = f;
        e.done_n = d;
        e.rdy_n  = r;
        sb.push_back(e);
    endtask

    // One frame: 3 cycles sync high, tick edge, 2 cycles low.
    task automatic frame(input string tag, input logic pwr);
        int         dn;
        int         rn;
        logic [6:0] fl;
        exp_t       e;
        dn = 0;
        rn = 0;
        VGA_VS = 1'b1;
        repeat (3) begin
            cyc();
            rn += int'(CMD_READY);
            dn += int'(FLASH_DONE);
        end
        VGA_VS   = 1'b0;
        POWER_ON = pwr;
        cyc();
        fl = SPRITES_FLAGS;
        rn += int'(CMD_READY);
        dn += int'(FLASH_DONE);
        repeat (2) begin
            cyc();
            rn += int'(CMD_READY);
            dn += int'(FLASH_DONE);
        end
        chk({"sb_has_", tag}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({"flags_", tag}, 32'(fl), 32'(e.flags));
            chk({"done_", tag}, 32'(dn), 32'(e.done_n));
            chk({"rdy_", tag}, 32'(rn), 32'(e.rdy_n));
        end
    endtask

    task automatic send(input string tag, input logic [1:0] op,
                        input logic [1:0] c);
        CMD_OP    = op;
        CMD_COLOR = c;
        CMD_VALID = 1'b1;
        chk({"ready_", tag}, 32'(CMD_READY), 32'd1);
        cyc();
        CMD_VALID = 1'b0;
    endtask

    // Accept on the same edge as a tick: flags must not move yet.
    task automatic send_on_tick(input string tag, input logic [1:0] op,
                                input logic [1:0] c);
        VGA_VS = 1'b1;
        cyc();
        VGA_VS    = 1'b0;
        CMD_OP    = op;
        CMD_COLOR = c;
        CMD_VALID = 1'b1;
        chk({"ready_", tag}, 32'(CMD_READY), 32'd1);
        cyc();
        CMD_VALID = 1'b0;
        chk({"hold_", tag}, 32'(SPRITES_FLAGS), 32'd0);
        chk({"armed_", tag}, 32'(CMD_READY), 32'd0);
        cyc();
        cyc();
    endtask

    task automatic run_flash(input string tag, input logic [1:0] c,
                             input logic on_tick);
        logic [6:0] m;
        m = 7'b1 << c;
        if (on_tick) begin
            send_on_tick(tag, 2'd0, c);
        end else begin
            send(tag, 2'd0, c);
        end
        push(m, 0, 0);
        push(m, 0, 0);
        push(m, 0, 0);
        push(7'h00, 0, 0);
        push(7'h00, 0, 0);
        push(7'h00, 1, 3);
        for (int i = 0; i < 6; i++) begin
            frame($sformatf("%s_f%0d", tag, i), 1'b0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RESET     = 1'b1;
        VGA_VS    = 1'b1;
        POWER_ON  = 1'b0;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'd0;
        CMD_COLOR = 2'd0;
        #1;
        chk("rst_flags", 32'(SPRITES_FLAGS), 32'd0);
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_done", 32'(FLASH_DONE), 32'd0);
        cyc();
        cyc();
        RESET = 1'b0;
        cyc();

        for (int i = 0; i < 3; i++) begin
            push(7'h00, 0, 6);
            frame($sformatf("idle%0d", i), 1'b0);
        end

        run_flash("red", 2'd2, 1'b0);
        chk("red_ready_after", 32'(CMD_READY), 32'd1);

        send("win", 2'd2, 2'd0);
        push(7'h20, 0, 3);
        push(7'h20, 0, 6);
        push(7'h00, 0, 6);
        push(7'h00, 0, 6);
        push(7'h20, 0, 6);
        push(7'h20, 0, 6);
        for (int i = 0; i < 6; i++) begin
            frame($sformatf("win%0d", i), 1'b0);
        end
        send("clear", 2'd3, 2'd0);
        push(7'h00, 0, 3);
        push(7'h00, 0, 6);
        frame("clear0", 1'b0);
        frame("clear1", 1'b0);

        send("lose", 2'd1, 2'd0);
        push(7'h10, 0, 3);
        push(7'h10, 0, 6);
        frame("lose0", 1'b0);
        frame("lose1", 1'b0);
        run_flash("blue_from_lose", 2'd0, 1'b0);

        run_flash("green_on_tick", 2'd1, 1'b1);

        send("yellow", 2'd0, 2'd3);
        push(7'h08, 0, 0);
        frame("yellow0", 1'b0);
        VGA_VS = 1'b1;
        cyc();
        RESET = 1'b1;
        #1;
        chk("midrst_flags", 32'(SPRITES_FLAGS), 32'd0);
        chk("midrst_ready", 32'(CMD_READY), 32'd1);
        chk("midrst_done", 32'(FLASH_DONE), 32'd0);
        cyc();
        RESET = 1'b0;
        cyc();
        push(7'h00, 0, 6);
        frame("post_rst_idle", 1'b0);
        run_flash("red_after_rst", 2'd2, 1'b0);

        push(7'h00, 0, 6);
        push(7'h40, 0, 6);
        push(7'h40, 0, 6);
        push(7'h00, 0, 6);
        frame("pwr0", 1'b1);
        frame("pwr1", 1'b1);
        frame("pwr2", 1'b0);
        frame("pwr3", 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
